// File: rtl/one_hot_rr_dispatch.sv
// Round-robin dispatcher: each accepted input entry lands in the first free
// single-entry output buffer at or after the rotating pointer.
module one_hot_rr_dispatch #(
    parameter int  N_OUTPUT = 4,
    parameter int  DATA_W   = 32,
    localparam int IDX_W    = $clog2(N_OUTPUT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       in_vld_i,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       in_rdy_o,
    output logic [N_OUTPUT-1:0]        out_vld_o,
    output logic [N_OUTPUT*DATA_W-1:0] out_data_o,
    input  logic [N_OUTPUT-1:0]        out_rdy_i,
    output logic [N_OUTPUT-1:0]        disp_oh_o,
    output logic [IDX_W-1:0]           disp_idx_o,
    output logic [IDX_W:0]             occ_o
);

    logic [N_OUTPUT-1:0] vld_q, vld_d;
    logic [N_OUTPUT-1:0] free;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    sel;
    logic [IDX_W:0]      cand;
    logic [IDX_W:0]      occ_q, occ_d;
    logic                found;
    logic                accept;
    logic [DATA_W-1:0]   data_q [N_OUTPUT];

    // A port draining this cycle can be refilled in the same cycle.
    assign free     = ~vld_q | out_rdy_i;
    assign in_rdy_o = (|free) & ~flush_i;
    assign accept   = in_vld_i & in_rdy_o;

    // Wrapping search upward from rr_ptr; cand is one bit wider so the
    // modulo fold works for non-power-of-two port counts.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_OUTPUT; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_OUTPUT)) begin
                cand = cand - (IDX_W+1)'(N_OUTPUT);
            end
            if (!found && free[cand[IDX_W-1:0]]) begin
                sel   = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign disp_oh_o  = accept ? (N_OUTPUT'(1) << sel) : '0;
    assign disp_idx_o = accept ? sel : '0;

    always_comb begin
        vld_d    = vld_q & ~out_rdy_i;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            vld_d[sel] = 1'b1;
            rr_ptr_d   = (sel == IDX_W'(N_OUTPUT-1)) ? '0 : sel + IDX_W'(1);
        end
        if (flush_i) begin
            vld_d    = '0;
            rr_ptr_d = '0;
        end
        occ_d = '0;
        for (int k = 0; k < N_OUTPUT; k++) begin
            occ_d = occ_d + (IDX_W+1)'(vld_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            rr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            rr_ptr_q <= rr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Payload only changes on a load into that port, so it is stable under backpressure.
    generate
        for (genvar gi = 0; gi < N_OUTPUT; gi++) begin : g_port
            always_ff @(posedge clk) begin
                if (accept && (sel == IDX_W'(gi))) begin
                    data_q[gi] <= in_data_i;
                end
            end
            assign out_data_o[gi*DATA_W +: DATA_W] = data_q[gi];
        end
    endgenerate

    assign out_vld_o = vld_q;
    assign occ_o     = occ_q;

endmodule

// File: tb/tb_one_hot_rr_dispatch.sv
// Bench for one_hot_rr_dispatch: directed scenarios plus random traffic,
// checked against a per-port buffer model with modulo round-robin search.
module tb_one_hot_rr_dispatch;

    logic         clk;
    logic         rst;
    logic         flush_i;
    logic         in_vld_i;
    logic [31:0]  in_data_i;
    logic         in_rdy_o;
    logic [3:0]   out_vld_o;
    logic [127:0] out_data_o;
    logic [3:0]   out_rdy_i;
    logic [3:0]   disp_oh_o;
    logic [1:0]   disp_idx_o;
    logic [2:0]   occ_o;

    logic         rst3;
    logic         flush3;
    logic         vld3;
    logic [31:0]  data3;
    logic         rdy3_o;
    logic [2:0]   vld3_o;
    logic [95:0]  data3_o;
    logic [2:0]   rdy3_i;
    logic [2:0]   oh3_o;
    logic [1:0]   idx3_o;
    logic [2:0]   occ3_o;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    bit          m_vld [4];
    logic [31:0] m_data [4];
    int          m_ptr;

    one_hot_rr_dispatch #(.N_OUTPUT(4), .DATA_W(32)) u_dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_vld_i(in_vld_i),
        .in_data_i(in_data_i), .in_rdy_o(in_rdy_o), .out_vld_o(out_vld_o),
        .out_data_o(out_data_o), .out_rdy_i(out_rdy_i), .disp_oh_o(disp_oh_o),
        .disp_idx_o(disp_idx_o), .occ_o(occ_o)
    );

    one_hot_rr_dispatch #(.N_OUTPUT(3), .DATA_W(32)) u_dut3 (
        .clk(clk), .rst(rst3), .flush_i(flush3), .in_vld_i(vld3),
        .in_data_i(data3), .in_rdy_o(rdy3_o), .out_vld_o(vld3_o),
        .out_data_o(data3_o), .out_rdy_i(rdy3_i), .disp_oh_o(oh3_o),
        .disp_idx_o(idx3_o), .occ_o(occ3_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_vld_vec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_vld[k];
        return v;
    endfunction

    // One clock cycle: drive, check combinational outputs mid-cycle, clock,
    // update the model, check registered state. exp_idx -1 = no directed
    // expectation, -2 = directed "no accept"; exp_occ -1 = none.
    task automatic do_cycle(input bit rs, input bit v, input logic [31:0] d,
                            input logic [3:0] r, input bit f,
                            input int exp_idx, input int exp_occ);
        bit any_free, found, acc;
        int sel, cnt, k;
        rst       = rs;
        in_vld_i  = v;
        in_data_i = d;
        out_rdy_i = r;
        flush_i   = f;

        any_free = 0;
        found    = 0;
        sel      = 0;
        for (int j = 0; j < 4; j++) begin
            k = (m_ptr + j) % 4;
            if (!m_vld[k] || r[k]) begin
                any_free = 1;
                if (!found) begin
                    sel   = k;
                    found = 1;
                end
            end
        end
        acc = v && any_free && !f;

        @(negedge clk);
        chk("in_rdy", 64'(in_rdy_o), 64'(any_free && !f));
        chk("disp_oh", 64'(disp_oh_o), acc ? 64'(1) << sel : 64'(0));
        chk("disp_idx", 64'(disp_idx_o), acc ? 64'(sel) : 64'(0));
        if (exp_idx >= 0) chk("spec_idx", 64'(disp_idx_o), 64'(exp_idx));
        if (exp_idx == -2) chk("spec_no_accept", 64'(disp_oh_o), 64'(0));

        @(posedge clk);
        #1;
        if (rs || f) begin
            for (int p = 0; p < 4; p++) m_vld[p] = 0;
            m_ptr = 0;
        end else begin
            for (int p = 0; p < 4; p++) if (m_vld[p] && r[p]) m_vld[p] = 0;
            if (acc) begin
                m_vld[sel]  = 1;
                m_data[sel] = d;
                m_ptr       = (sel + 1) % 4;
            end
        end
        cnt = 0;
        for (int p = 0; p < 4; p++) cnt += int'(m_vld[p]);
        chk("out_vld", 64'(out_vld_o), 64'(model_vld_vec()));
        chk("occ", 64'(occ_o), 64'(cnt));
        if (exp_occ >= 0) chk("spec_occ", 64'(occ_o), 64'(exp_occ));
        for (int p = 0; p < 4; p++) begin
            if (m_vld[p]) chk($sformatf("data%0d", p), 64'(out_data_o[p*32 +: 32]), 64'(m_data[p]));
        end
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_vld_i = 1'b0; in_data_i = '0; out_rdy_i = '0;
        rst3 = 1'b1; flush3 = 1'b0; vld3 = 1'b0; data3 = '0; rdy3_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int p = 0; p < 4; p++) m_vld[p] = 0;
        m_ptr = 0;

        // Reset state
        chk("rst_out_vld", 64'(out_vld_o), 64'(0));
        chk("rst_occ", 64'(occ_o), 64'(0));
        chk("rst_disp_oh", 64'(disp_oh_o), 64'(0));
        chk("rst_disp_idx", 64'(disp_idx_o), 64'(0));
        chk("rst_in_rdy", 64'(in_rdy_o), 64'(1));

        // Fill all four ports under backpressure, then a fifth is refused
        for (int i = 0; i < 4; i++) do_cycle(0, 1, 32'hA0 + 32'(i), 4'b0000, 0, i, i + 1);
        do_cycle(0, 1, 32'hAF, 4'b0000, 0, -2, 4);

        // Same-cycle drain and refill of port 2
        do_cycle(0, 1, 32'hB0, 4'b0100, 0, 2, 4);
        chk("full_vld", 64'(out_vld_o), 64'hF);
        chk("port2_data", 64'(out_data_o[64 +: 32]), 64'hB0);

        // rr_ptr at 3, ports 3 and 0 busy: wrap to port 1
        do_cycle(0, 1, 32'hB1, 4'b0110, 0, 1, 3);
        chk("wrap_vld", 64'(out_vld_o), 64'hB);

        // Flush with occupancy 3
        do_cycle(0, 1, 32'hC0, 4'b0000, 1, -2, 0);
        chk("flush_vld", 64'(out_vld_o), 64'h0);
        do_cycle(0, 1, 32'hC1, 4'b0000, 0, 0, 1);

        // Reset mid-operation with an accept pending
        do_cycle(0, 1, 32'hC2, 4'b0000, 0, 1, 2);
        do_cycle(1, 1, 32'hC3, 4'b0000, 0, -1, 0);
        chk("rst_mid_vld", 64'(out_vld_o), 64'h0);
        do_cycle(0, 1, 32'hC4, 4'b1111, 0, 0, 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            do_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom,
                     4'($urandom), $urandom_range(0, 19) == 0, -1, -1);
        end

        // Three-port build: back-to-back accepts with all consumers ready
        rst3   = 1'b0;
        vld3   = 1'b1;
        rdy3_i = 3'b111;
        for (int i = 0; i < 7; i++) begin
            data3 = 32'hD0 + 32'(i);
            @(negedge clk);
            chk($sformatf("n3_idx%0d", i), 64'(idx3_o), 64'(i % 3));
            @(posedge clk);
            #1;
        end
        chk("n3_occ", 64'(occ3_o), 64'(1));
        chk("n3_vld", 64'(vld3_o), 64'b001);
        chk("n3_data0", 64'(data3_o[0 +: 32]), 64'hD6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/one_hot_rr_dispatch.md
ONE_HOT_RR_DISPATCH -- requirements
Module: one_hot_rr_dispatch

Interface
REQ-001 SHALL have parameter N_OUTPUT, default 4, number of output ports (>=2, not required to be a power of two).
REQ-002 SHALL have parameter DATA_W, default 32, payload width.
REQ-003 SHALL define IDX_W = $clog2(N_OUTPUT) as a derived, non-overridable width.
REQ-004 SHALL have clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have flush_i  input  1  drop all buffered entries.
REQ-007 SHALL have in_vld_i  input  1  input entry valid.
REQ-008 SHALL have in_data_i  input  DATA_W  input payload.
REQ-009 SHALL have in_rdy_o  output  1  input accepted this cycle when in_vld_i is also high.
REQ-010 SHALL have out_vld_o  output  N_OUTPUT  per-port buffered entry valid.
REQ-011 SHALL have out_data_o  output  N_OUTPUT*DATA_W  per-port payload; port k occupies bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have out_rdy_i  input  N_OUTPUT  per-port consumer ready.
REQ-013 SHALL have disp_oh_o  output  N_OUTPUT  one-hot target port of the current accept; zero when no accept.
REQ-014 SHALL have disp_idx_o  output  IDX_W  binary index of disp_oh_o; 0 when no accept.
REQ-015 SHALL have occ_o  output  IDX_W+1  number of ports holding a valid entry.

Function
REQ-016 SHALL hold one entry buffer per output port: a valid bit and a DATA_W data register.
REQ-017 SHALL treat port k as free when out_vld_o[k]==0, or out_vld_o[k]==1 and out_rdy_i[k]==1 (same-cycle drain and refill).
REQ-018 SHALL assert in_rdy_o = (any port free) and not flush_i; in_rdy_o is combinational and independent of in_vld_i.
REQ-019 SHALL select the target as the first free port searching upward from rr_ptr, wrapping from N_OUTPUT-1 to 0.
REQ-020 SHALL drive disp_oh_o/disp_idx_o combinationally to the selected port only when in_vld_i && in_rdy_o.
REQ-021 SHALL, on accept, load in_data_i into the selected port's buffer and set its valid bit at the next edge; latency in-to-out is 1 cycle.
REQ-022 SHALL, on accept, update rr_ptr to sel+1, or 0 when sel==N_OUTPUT-1; rr_ptr holds otherwise.
REQ-023 SHALL clear port k's valid bit when out_vld_o[k]&&out_rdy_i[k] and port k is not being reloaded in the same cycle.
REQ-024 SHALL not alter a valid port's data while out_rdy_i[k]==0 (payload stable under backpressure).
REQ-025 SHALL, when flush_i is high, clear all valid bits and reset rr_ptr to 0 at the next edge; no accept occurs that cycle.
REQ-026 SHALL compute occ_o as the registered population count of the valid bits, i.e. the value after the current edge's updates.
REQ-027 SHALL keep rr_ptr in 0..N_OUTPUT-1 at all times, including non-power-of-two N_OUTPUT.
REQ-028 SHALL leave out_data_o content don't-care for ports with out_vld_o low; only out_vld_o is contractual.

Reset
REQ-029 SHALL, while rst is high at a clock edge, clear all valid bits and rr_ptr to 0; rst has priority over flush_i and accept.
REQ-030 SHALL present after reset: out_vld_o=0, occ_o=0, disp_oh_o=0, disp_idx_o=0, and in_rdy_o=1 (when flush_i is low).
REQ-031 SHALL discard any in-flight accept when rst is asserted mid-operation; data registers need no reset.

Verification
REQ-032 Reset, then in_vld_i=1 for 4 cycles with data 0xA0..0xA3 and out_rdy_i=0 -> disp_idx_o 0,1,2,3; occ_o 1,2,3,4; cycle 5 in_rdy_o=0.
REQ-033 All ports full, out_rdy_i=4'b0100, in_vld_i=1 data 0xB0 -> same-cycle accept to port 2; out_vld_o stays 4'b1111; port 2 data becomes 0xB0.
REQ-034 rr_ptr=3 (after three accepts), ports 3 and 0 busy, ports 1 and 2 free -> select port 1 (wrap skip); rr_ptr becomes 2.
REQ-035 N_OUTPUT=3 build, 7 back-to-back accepts with all out_rdy_i=1 -> disp_idx_o sequence 0,1,2,0,1,2,0.
REQ-036 occ_o=3 with in_vld_i=1 and flush_i=1 -> no accept, disp_oh_o=0; next cycle out_vld_o=0, occ_o=0, next accept goes to port 0.
REQ-037 rst asserted for 1 cycle with 2 valid entries and an accept pending -> following cycle out_vld_o=0, occ_o=0, rr_ptr=0.
